// File: rtl/mdu_hilo_writer_if.sv
// mdu_hilo_writer_if
// ------------------
// Bundles the operand request and the HI/LO write signals of the iterative
// multiply/divide unit.
//
// Signals:
//   start        request from the execute stage, honoured only while busy=0
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a        multiplicand / dividend (rs)
//   src_b        multiplier / divisor (rt)
//   flush        abort whatever is in flight, suppressing any write
//   busy         unit is occupied (includes the write cycle)
//   write_hi_en  HI write strobe
//   write_lo_en  LO write strobe
//   hi_data      product[63:32] or remainder
//   lo_data      product[31:0] or quotient
//
// Modports:
//   master  the issuing side (execute stage / testbench)
//   slave   the multiply/divide unit itself
interface mdu_hilo_writer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        write_hi_en;
    logic        write_lo_en;
    logic [31:0] hi_data;
    logic [31:0] lo_data;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, write_hi_en, write_lo_en, hi_data, lo_data
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, write_hi_en, write_lo_en, hi_data, lo_data
    );
endinterface

// File: rtl/mdu_hilo_writer.sv
// mdu_hilo_writer
// ---------------
// Iterative multiply/divide unit that produces the HI/LO register write.
// A request is accepted in IDLE when start=1 and flush=0; the operands are
// latched and the unit stays busy until it emits a one-cycle write pulse on
// write_hi_en/write_lo_en together with hi_data/lo_data.
//
//   Multiply : pulse MUL_LATENCY cycles after accept (signed or unsigned
//              32x32->64, HI = upper word, LO = lower word).
//   Divide   : 32 restoring iterations on operand magnitudes, one sign-fix
//              cycle, then the write cycle (pulse 34 cycles after accept).
//              LO = quotient (truncating), HI = remainder (dividend's sign).
//              Divide by zero yields LO=0xFFFF_FFFF, HI=raw dividend.
//
// Ports:
//   clk     clock, all state on posedge
//   resetn  asynchronous active-low reset
//   bus     mdu_hilo_writer_if.slave (request in, busy/write out)
//
// Parameters:
//   MUL_LATENCY  accept-to-write latency for multiplies, 1..8
//   DIV_ITERS    number of restoring division iterations (word width, 32)
module mdu_hilo_writer #(
    parameter int MUL_LATENCY = 2,
    parameter int DIV_ITERS   = 32
) (
    input  logic                clk,
    input  logic                resetn,
    mdu_hilo_writer_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        WRITE
    } state_t;

    // Final values of the shared counter for the two iterative paths.
    // MUL_LAST is meaningless when MUL_LATENCY=1 since MUL is skipped then.
    localparam logic [4:0] MUL_LAST = 5'(MUL_LATENCY - 2);
    localparam logic [4:0] DIV_LAST = 5'(DIV_ITERS - 1);

    state_t      state;
    logic [4:0]  cnt;

    // Operands as presented at accept; later bus changes cannot disturb them.
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        signed_q;

    // Division datapath: partial remainder, quotient/dividend shift register
    // and the divisor magnitude.
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] divisor_q;
    logic        neg_quo_q;
    logic        neg_rem_q;

    // Result registers that drive hi_data/lo_data.
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        accept;
    logic        in_signed;
    logic [63:0] mul_product;
    logic [32:0] trial;
    logic [32:0] diff;

    // Sign-extends (or zero-extends) both operands to 64 bits so that a
    // single 64-bit multiply yields the correct low 64 product bits for both
    // the signed and the unsigned flavour.
    function automatic logic [63:0] mul64(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{sgn & a[31]}}, a};
        eb = {{32{sgn & b[31]}}, b};
        return ea * eb;
    endfunction

    // Absolute value for signed ops; unsigned ops pass through untouched.
    // 0x8000_0000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] negate_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    assign accept    = (state == IDLE) && bus.start && !bus.flush;
    assign in_signed = ~bus.op[0];

    assign mul_product = mul64(a_q, b_q, signed_q);

    // One restoring step: shift the next dividend bit into the remainder and
    // try to subtract the divisor. The trial value needs 33 bits because the
    // shifted remainder can exceed 32 bits when the divisor is large; a
    // borrow (diff[32]) means the subtraction must be discarded.
    assign trial = {rem_q, quo_q[31]};
    assign diff  = trial - {1'b0, divisor_q};

    // Control FSM and datapath. flush takes priority over everything once an
    // operation is in flight; in IDLE it simply blocks acceptance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            signed_q  <= 1'b0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            divisor_q <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else if (bus.flush && (state != IDLE)) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q      <= bus.src_a;
                        b_q      <= bus.src_b;
                        signed_q <= in_signed;
                        cnt      <= 5'd0;
                        if (!bus.op[1]) begin
                            // With single-cycle latency the product is taken
                            // straight from the bus and MUL is skipped.
                            if (MUL_LATENCY == 1) begin
                                {hi_q, lo_q} <= mul64(bus.src_a, bus.src_b, in_signed);
                                state        <= WRITE;
                            end else begin
                                state <= MUL;
                            end
                        end else begin
                            rem_q     <= 32'd0;
                            quo_q     <= mag(bus.src_a, in_signed);
                            divisor_q <= mag(bus.src_b, in_signed);
                            neg_quo_q <= in_signed & (bus.src_a[31] ^ bus.src_b[31]);
                            neg_rem_q <= in_signed & bus.src_a[31];
                            state     <= DIV;
                        end
                    end
                end

                MUL: begin
                    if (cnt == MUL_LAST) begin
                        {hi_q, lo_q} <= mul_product;
                        cnt          <= 5'd0;
                        state        <= WRITE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end

                DIV: begin
                    if (!diff[32]) begin
                        rem_q <= diff[31:0];
                        quo_q <= {quo_q[30:0], 1'b1};
                    end else begin
                        rem_q <= trial[31:0];
                        quo_q <= {quo_q[30:0], 1'b0};
                    end
                    if (cnt == DIV_LAST) begin
                        cnt   <= 5'd0;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end

                FIX: begin
                    // A zero divisor still runs all iterations so latency is
                    // data independent; its architectural result is forced
                    // here from the raw dividend.
                    if (b_q == 32'd0) begin
                        hi_q <= a_q;
                        lo_q <= 32'hFFFF_FFFF;
                    end else begin
                        hi_q <= negate_if(rem_q, neg_rem_q);
                        lo_q <= negate_if(quo_q, neg_quo_q);
                    end
                    state <= WRITE;
                end

                WRITE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes are gated by flush combinationally so that a flush arriving in
    // the write cycle itself still suppresses the write.
    assign bus.busy        = (state != IDLE);
    assign bus.write_hi_en = (state == WRITE) && !bus.flush;
    assign bus.write_lo_en = (state == WRITE) && !bus.flush;
    assign bus.hi_data     = hi_q;
    assign bus.lo_data     = lo_q;

endmodule

// File: tb/tb_mdu_hilo_writer.sv
// tb_mdu_hilo_writer
// ------------------
// Self-checking bench for mdu_hilo_writer. A behavioural model tracks
// "cycles since accept" and predicts HI/LO from plain integer arithmetic;
// a compare process checks busy, both strobes and (in the write cycle) the
// data on every falling edge. Directed cases pin literal results and
// latencies, then a randomized phase exercises start/flush/operand mixes.
module tb_mdu_hilo_writer;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 34;

    logic clk = 1'b0;
    logic resetn;

    mdu_hilo_writer_if bus();

    mdu_hilo_writer #(
        .MUL_LATENCY(MUL_LAT),
        .DIV_ITERS  (32)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: whether an operation is in flight, which cycle after
    // accept we are in, when the write is due and what it must carry.
    logic        m_active = 1'b0;
    int          m_cyc    = 0;
    int          m_lat    = 0;
    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;

    logic        exp_busy;
    logic        exp_wr;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, straight from integer rules.
    function automatic void predict(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output int lat, output logic [31:0] hi, output logic [31:0] lo);
        int          ia;
        int          ib;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        hi = 32'd0;
        lo = 32'd0;
        if (!op[1]) begin
            lat = MUL_LAT;
            if (op[0]) p = {32'd0, a} * {32'd0, b};
            else       p = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else begin
            lat = DIV_LAT;
            if (b == 32'd0) begin
                hi = a;
                lo = 32'hFFFF_FFFF;
            end else if (op[0]) begin
                hi = a % b;
                lo = a / b;
            end else begin
                q  = sa / sb;
                r  = sa % sb;
                hi = r[31:0];
                lo = q[31:0];
            end
        end
    endfunction

    // Model update on the same edges the DUT uses.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if (bus.flush || (m_cyc == m_lat)) m_active = 1'b0;
            else                               m_cyc++;
        end else if (bus.start && !bus.flush) begin
            m_active = 1'b1;
            m_cyc    = 1;
            predict(bus.op, bus.src_a, bus.src_b, m_lat, m_hi, m_lo);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        exp_busy = m_active;
        exp_wr   = m_active && (m_cyc == m_lat) && !bus.flush;
        checkOutput("busy",  {31'd0, bus.busy},        {31'd0, exp_busy});
        checkOutput("wr_hi", {31'd0, bus.write_hi_en}, {31'd0, exp_wr});
        checkOutput("wr_lo", {31'd0, bus.write_lo_en}, {31'd0, exp_wr});
        if (exp_wr) begin
            checkOutput("model_hi", bus.hi_data, m_hi);
            checkOutput("model_lo", bus.lo_data, m_lo);
        end
    end

    function automatic logic [31:0] pickOperand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(1, 20));
            4:       v = 32'd0 - 32'($urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Presents a request for one cycle; returns #1 into cycle 1.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Called #1 into cycle 1. Waits (bounded) for the write pulse and checks
    // its cycle and data; operands are scrambled each cycle, and start is
    // pulsed during cycles junk_lo..junk_hi. Returns at the pulse's negedge.
    task automatic waitWrite(input string name, input int exp_lat,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                             input int junk_lo, input int junk_hi);
        int k;
        bit seen;
        k    = 1;
        seen = 1'b0;
        while (k <= 60 && !seen) begin
            @(negedge clk);
            if (bus.write_hi_en) begin
                seen = 1'b1;
                checkOutput({name, "_cycle"}, 32'(k), 32'(exp_lat));
                checkOutput({name, "_wr_lo"}, {31'd0, bus.write_lo_en}, 32'd1);
                checkOutput({name, "_hi"}, bus.hi_data, exp_hi);
                checkOutput({name, "_lo"}, bus.lo_data, exp_lo);
            end else begin
                @(posedge clk);
                #1;
                k++;
                bus.start = (k >= junk_lo) && (k <= junk_hi);
                bus.op    = 2'($urandom);
                bus.src_a = $urandom;
                bus.src_b = $urandom;
            end
        end
        if (!seen) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
        bus.start = 1'b0;
    endtask

    task automatic countStrobes(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.write_hi_en || bus.write_lo_en) n++;
        end
    endtask

    task automatic advanceTo(input int from_cyc, input int to_cyc);
        for (int i = from_cyc; i < to_cyc; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int strobes;

    initial begin
        $display("[TB] mdu_hilo_writer bench start");
        resetn    = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = 32'd0;
        bus.src_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy",  {31'd0, bus.busy},        32'd0);
        checkOutput("rst_wr_hi", {31'd0, bus.write_hi_en}, 32'd0);
        checkOutput("rst_hi",    bus.hi_data,              32'd0);
        checkOutput("rst_lo",    bus.lo_data,              32'd0);
        @(posedge clk);
        #2;
        resetn = 1'b1;

        // Multiplies
        applyStimulus(2'b00, 32'hFFFF_FFFE, 32'd3);
        checkOutput("mult_busy_c1", {31'd0, bus.busy}, 32'd1);
        waitWrite("mult_neg", 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, -1);
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitWrite("multu_max", 2, 32'hFFFF_FFFE, 32'h0000_0001, 0, -1);
        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitWrite("mult_m1", 2, 32'h0000_0000, 32'h0000_0001, 0, -1);

        // Divides, then a back-to-back multiply in the first IDLE cycle
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2);
        waitWrite("div_neg", 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, -1);
        applyStimulus(2'b11, 32'd7, 32'd2);
        waitWrite("divu_7_2", 34, 32'd1, 32'd3, 0, -1);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        waitWrite("div_ovf", 34, 32'h0000_0000, 32'h8000_0000, 0, -1);
        applyStimulus(2'b01, 32'h0001_0000, 32'h0001_0000);
        checkOutput("b2b_busy_c1", {31'd0, bus.busy}, 32'd1);
        waitWrite("b2b_multu", 2, 32'd1, 32'd0, 0, -1);

        // Divide by zero with ignored starts during cycles 5..20
        applyStimulus(2'b11, 32'd100, 32'd0);
        waitWrite("divu_zero", 34, 32'd100, 32'hFFFF_FFFF, 5, 20);
        countStrobes(40, strobes);
        checkOutput("divu_zero_single", 32'(strobes), 32'd0);

        // Flush in cycle 10 of a divide
        applyStimulus(2'b10, 32'd1000, 32'd7);
        advanceTo(1, 10);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        checkOutput("flush_busy_c11", {31'd0, bus.busy}, 32'd0);
        countStrobes(40, strobes);
        checkOutput("flush_no_write", 32'(strobes), 32'd0);

        // Flush in the write cycle of a multiply
        applyStimulus(2'b00, 32'd5, 32'd6);
        advanceTo(1, 2);
        bus.flush = 1'b1;
        #3;
        checkOutput("flushw_wr_hi", {31'd0, bus.write_hi_en}, 32'd0);
        checkOutput("flushw_wr_lo", {31'd0, bus.write_lo_en}, 32'd0);
        checkOutput("flushw_busy",  {31'd0, bus.busy},        32'd1);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        checkOutput("flushw_idle", {31'd0, bus.busy}, 32'd0);

        // start together with flush in IDLE
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = 2'b01;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        checkOutput("start_flush_idle", {31'd0, bus.busy}, 32'd0);

        // Async reset in the middle of cycle 15 of a divide
        applyStimulus(2'b11, 32'd12345, 32'd17);
        advanceTo(1, 15);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("arst_busy",  {31'd0, bus.busy},        32'd0);
        checkOutput("arst_wr_hi", {31'd0, bus.write_hi_en}, 32'd0);
        checkOutput("arst_hi",    bus.hi_data,              32'd0);
        checkOutput("arst_lo",    bus.lo_data,              32'd0);
        @(posedge clk);
        #2;
        resetn = 1'b1;
        countStrobes(50, strobes);
        checkOutput("arst_no_write", 32'(strobes), 32'd0);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            bus.start = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 49) == 0);
            bus.op    = 2'($urandom);
            bus.src_a = pickOperand();
            bus.src_b = pickOperand();
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_hilo_writer.md
Name: mdu_hilo_writer

Overview:
- Iterative multiply/divide unit; the producer side of the HI/LO register write interface.
- Accepts MULT/MULTU/DIV/DIVU operands from the execute stage and computes for several cycles.
- Delivers the result as a single-cycle write pulse on write_hi_en/write_lo_en with hi_data/lo_data.
- The HI/LO register forwards the write combinationally, so a consumer sees the new value in the write cycle itself.

Parameters:
- MUL_LATENCY, 2: cycles from accept to the write pulse for multiplies; legal range 1..8.
- DIV_ITERS, 32: restoring-division iterations, one quotient bit per cycle; fixed at the word width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled at accept.
- src_a  in  32  multiplicand/dividend (rs); sampled at accept.
- src_b  in  32  multiplier/divisor (rt); sampled at accept.
- flush  in  1  abort any operation in flight; no write is produced.
- busy  out  1  high whenever state != IDLE, including the write cycle.
- write_hi_en  out  1  HI write strobe.
- write_lo_en  out  1  LO write strobe.
- hi_data  out  32  HI value: product[63:32] or remainder.
- lo_data  out  32  LO value: product[31:0] or quotient.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, all counters, operand and result registers cleared.
  - busy=0, write_hi_en=0, write_lo_en=0, hi_data=0, lo_data=0.
  - Reset released mid-operation produces no write.
- States: IDLE, MUL, DIV, FIX, WRITE.
- Accept (cycle 0): IDLE & start & ~flush. Latch op/src_a/src_b; busy rises in cycle 1.
- Multiply path:
  - IDLE→MUL; counter counts MUL_LATENCY-1 cycles, then →WRITE.
  - Write pulse is in cycle MUL_LATENCY after accept.
  - MULT: signed 32x32→64. MULTU: unsigned 32x32→64.
  - hi_data = product[63:32], lo_data = product[31:0].
- Divide path:
  - IDLE→DIV. Take magnitudes of operands (signed ops only); 64-bit remainder/quotient shift register.
  - 32 restoring iterations in cycles 1..32, then FIX in cycle 33, then WRITE in cycle 34.
  - FIX sign rules:
    - Quotient is negated if the operand signs differ.
    - Remainder takes the dividend's sign (truncating division).
  - Divisor zero: no iteration shortcut, same latency; lo_data=32'hFFFF_FFFF, hi_data=src_a (raw value, for both DIV and DIVU).
  - DIV 0x8000_0000 / 0xFFFF_FFFF: lo_data=0x8000_0000, hi_data=0 (falls out of the magnitude algorithm; verify explicitly).
- WRITE state:
  - write_hi_en=write_lo_en=1 for exactly one cycle, hi_data/lo_data valid.
  - Strobes are always asserted together; never one without the other.
  - Next state IDLE; busy drops the following cycle.
  - A new start is accepted in the first IDLE cycle, giving back-to-back operations a one-cycle bubble.
- Outside the WRITE cycle, strobes=0. hi_data/lo_data hold their last value (don't-care for the consumer).
- start while busy: ignored and not queued; the upstream stage must stall on busy.
- flush:
  - From any non-IDLE state: →IDLE next cycle; no write pulse, even if state is WRITE (strobes are gated by ~flush combinationally).
  - flush with start in IDLE: start is not accepted.
- op/src_a/src_b changes after accept have no effect on the result.

Test Plan:
- MULT src_a=0xFFFF_FFFE (-2), src_b=3, MUL_LATENCY=2 -> write pulse in cycle 2 after accept; hi=0xFFFF_FFFF, lo=0xFFFF_FFFA; busy high cycles 1-2.
- MULTU 0xFFFF_FFFF*0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001; MULT of same operands -> hi=0, lo=1.
- DIV -7/2 -> pulse in cycle 34, lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1); DIVU 7/2 -> lo=3, hi=1; DIV 0x8000_0000/-1 -> lo=0x8000_0000, hi=0.
- DIVU 100/0 -> cycle 34, lo=0xFFFF_FFFF, hi=100; start pulsed during cycles 5-20 -> ignored, exactly one write pulse.
- DIV started, flush in cycle 10 -> busy=0 in cycle 11, no write pulse ever; MULT with flush asserted in its WRITE cycle -> strobes stay 0; start+flush in IDLE -> not accepted.
- Async reset asserted in cycle 15 of a DIV, mid-clock -> busy and strobes drop immediately, no write after release; back-to-back MULTU after a completed DIV accepted on the first IDLE cycle.
